// File: rtl/acl2_spi_sequencer_if.sv
// -----------------------------------------------------------------------------
// acl2_spi_sequencer_if
// Host-side request/response bundle for the ADXL362 transaction sequencer.
//   start       : request strobe (host -> sequencer)
//   op          : 00 write, 01 read, 10 FIFO read, 11 read
//   addr, wdata : register address / write data byte
//   len         : data byte count 1..15 (0 means 1)
//   rdata       : last captured data byte (sequencer -> host)
//   rdata_valid : one-cycle strobe when rdata updates
//   busy, done  : transaction in flight / one-cycle end strobe
// master = host side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface acl2_spi_sequencer_if;
    logic       start;
    logic [1:0] op;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [3:0] len;
    logic [7:0] rdata;
    logic       rdata_valid;
    logic       busy;
    logic       done;

    modport master (
        output start, op, addr, wdata, len,
        input  rdata, rdata_valid, busy, done
    );

    modport slave (
        input  start, op, addr, wdata, len,
        output rdata, rdata_valid, busy, done
    );
endinterface

// File: rtl/acl2_spi_sequencer.sv
// -----------------------------------------------------------------------------
// acl2_spi_sequencer
// Frames one ADXL362 register write, register read or FIFO read on top of a
// free-running SPI byte engine. Bytes are swapped on the engine's byte_done
// edge; received data bytes are captured on the following byte_begin edge.
// Ports:
//   sclk_o         : clock, all updates on posedge
//   rst            : asynchronous active-high reset
//   bus            : host request/response (acl2_spi_sequencer_if.slave)
//   spi_byte_done  : engine bit counter == 7
//   spi_byte_begin : engine bit counter == 0, spi_rx_data holds previous byte
//   spi_rx_data    : engine receive shift register
//   ncs_o          : chip select, active low
//   spi_tx_data    : byte the engine is currently shifting out
// -----------------------------------------------------------------------------
module acl2_spi_sequencer #(
    parameter logic [7:0] CMD_WRITE = 8'h0A,
    parameter logic [7:0] CMD_READ  = 8'h0B,
    parameter logic [7:0] CMD_FIFO  = 8'h0D
) (
    input  logic                        sclk_o,
    input  logic                        rst,
    acl2_spi_sequencer_if.slave         bus,
    input  logic                        spi_byte_done,
    input  logic                        spi_byte_begin,
    input  logic [7:0]                  spi_rx_data,
    output logic                        ncs_o,
    output logic [7:0]                  spi_tx_data
);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_TAIL} state_t;

    state_t     r_state;
    logic [1:0] r_op;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic [3:0] r_rem;
    logic       r_pend;
    logic       r_cap;      // byte now completing was a data byte of a read
    logic       r_ncs;
    logic [7:0] r_tx;
    logic [7:0] r_rdata;
    logic       r_rdata_valid;
    logic       r_busy;
    logic       r_done;

    logic       w_wr;
    logic       w_fifo;
    logic [7:0] w_cmd;

    assign w_wr   = (r_op == 2'b00);
    assign w_fifo = (r_op == 2'b10);
    assign w_cmd  = w_wr ? CMD_WRITE : (w_fifo ? CMD_FIFO : CMD_READ);

    assign ncs_o           = r_ncs;
    assign spi_tx_data     = r_tx;
    assign bus.rdata       = r_rdata;
    assign bus.rdata_valid = r_rdata_valid;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;

    always_ff @(posedge sclk_o or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_op          <= 2'b00;
            r_addr        <= 8'h00;
            r_wdata       <= 8'h00;
            r_rem         <= 4'd1;
            r_pend        <= 1'b0;
            r_cap         <= 1'b0;
            r_ncs         <= 1'b1;
            r_tx          <= 8'h00;
            r_rdata       <= 8'h00;
            r_rdata_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_rdata_valid <= 1'b0;
            r_done        <= 1'b0;

            // byte_begin never coincides with byte_done, so capture can sit
            // beside the state machine without conflicting with r_cap set.
            if (spi_byte_begin && r_cap) begin
                r_rdata       <= spi_rx_data;
                r_rdata_valid <= 1'b1;
                r_cap         <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.start && !r_busy) begin
                        r_op    <= bus.op;
                        r_addr  <= bus.addr;
                        r_wdata <= bus.wdata;
                        r_rem   <= (bus.len == 4'd0) ? 4'd1 : bus.len;
                        r_pend  <= 1'b1;
                        r_busy  <= 1'b1;
                    end else if (r_pend && spi_byte_done) begin
                        r_ncs   <= 1'b0;
                        r_tx    <= w_cmd;
                        r_pend  <= 1'b0;
                        r_state <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (spi_byte_done) begin
                        if (w_fifo) begin
                            r_tx    <= 8'h00;
                            r_state <= S_DATA;
                        end else begin
                            r_tx    <= r_addr;
                            r_state <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    if (spi_byte_done) begin
                        r_tx    <= w_wr ? r_wdata : 8'h00;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (spi_byte_done) begin
                        r_rem <= r_rem - 4'd1;
                        r_cap <= !w_wr;
                        if (r_rem == 4'd1) begin
                            r_ncs   <= 1'b1;
                            r_state <= S_TAIL;
                        end
                    end
                end
                S_TAIL: begin
                    // Final data byte is captured by the shared capture path.
                    if (spi_byte_begin) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_tx    <= 8'h00;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acl2_spi_sequencer.sv
module tb_acl2_spi_sequencer;

    logic       sclk_o = 1'b0;
    logic       rst    = 1'b1;
    logic       spi_byte_done;
    logic       spi_byte_begin;
    logic [7:0] spi_rx_data;
    logic       ncs_o;
    logic [7:0] spi_tx_data;

    acl2_spi_sequencer_if bus();

    acl2_spi_sequencer dut (
        .sclk_o         (sclk_o),
        .rst            (rst),
        .bus            (bus),
        .spi_byte_done  (spi_byte_done),
        .spi_byte_begin (spi_byte_begin),
        .spi_rx_data    (spi_rx_data),
        .ncs_o          (ncs_o),
        .spi_tx_data    (spi_tx_data)
    );

    always #5 sclk_o = ~sclk_o;

    // ---------------- engine + slave model ----------------
    logic [2:0] cnt = 3'd0;
    logic [7:0] rx_sh = 8'h00;
    int         byte_idx = 0;
    logic [7:0] miso_tab [0:17];
    logic [7:0] miso_byte;

    assign spi_byte_done  = (cnt == 3'd7);
    assign spi_byte_begin = (cnt == 3'd0);
    assign spi_rx_data    = rx_sh;
    assign miso_byte      = miso_tab[(byte_idx < 18) ? byte_idx : 17];

    always @(posedge sclk_o) begin
        cnt <= cnt + 3'd1;
        if (!ncs_o) rx_sh <= {rx_sh[6:0], miso_byte[3'd7 - cnt]};
        if (ncs_o) byte_idx <= 0;
        else if (cnt == 3'd7) byte_idx <= byte_idx + 1;
    end

    // ---------------- scoreboard ----------------
    typedef struct { int low; bit rv; } done_t;
    logic [7:0] exp_mosi_q [$];
    logic [7:0] exp_rd_q   [$];
    done_t      exp_done_q [$];

    int n_chk  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on negedge, pops expectations whenever the DUT shows
    // a MOSI byte, an rdata_valid strobe or a done strobe.
    initial begin
        int         low_cnt  = 0;
        int         cyc      = 0;
        int         last_rv  = 0;
        bit         have_rv  = 0;
        bit         prev_ncs = 1;
        logic [7:0] mosi_sh  = 8'h00;
        done_t      d;
        forever begin
            @(negedge sclk_o);
            cyc++;
            if (rst || !mon_en) begin
                low_cnt  = 0;
                have_rv  = 0;
                prev_ncs = ncs_o;
            end else begin
                if (prev_ncs && !ncs_o) chk("ncs_fall_phase", int'(cnt), 0);
                if (!ncs_o) begin
                    low_cnt++;
                    mosi_sh = {mosi_sh[6:0], spi_tx_data[3'd7 - cnt]};
                    if (cnt == 3'd7) begin
                        chk("mosi_expected", int'(exp_mosi_q.size() > 0), 1);
                        if (exp_mosi_q.size() > 0) chk("mosi_byte", int'(mosi_sh), int'(exp_mosi_q.pop_front()));
                    end
                end
                if (bus.rdata_valid) begin
                    chk("rv_expected", int'(exp_rd_q.size() > 0), 1);
                    if (exp_rd_q.size() > 0) chk("rdata", int'(bus.rdata), int'(exp_rd_q.pop_front()));
                    if (have_rv) chk("rv_gap", cyc - last_rv, 8);
                    last_rv = cyc;
                    have_rv = 1;
                end
                if (bus.done) begin
                    chk("done_expected", int'(exp_done_q.size() > 0), 1);
                    if (exp_done_q.size() > 0) begin
                        d = exp_done_q.pop_front();
                        chk("ncs_low_edges", low_cnt, d.low);
                        chk("done_with_rv", int'(bus.rdata_valid), int'(d.rv));
                    end
                    low_cnt = 0;
                    have_rv = 0;
                end
                prev_ncs = ncs_o;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge sclk_o);
            n++;
        end while (bus.busy && n < 400);
        chk(name, int'(bus.busy), 0);
    endtask

    task automatic pulse_start(input logic [1:0] op_i, input logic [7:0] a,
                               input logic [7:0] w, input logic [3:0] l);
        bus.op    = op_i;
        bus.addr  = a;
        bus.wdata = w;
        bus.len   = l;
        bus.start = 1'b1;
        @(negedge sclk_o);
        bus.start = 1'b0;
    endtask

    // Queues the expected wire bytes, read data and frame length, then issues
    // the request at engine phase ph. Optionally waits for completion.
    task automatic run_txn(input logic [1:0] op_i, input logic [7:0] a, input logic [7:0] w,
                           input logic [3:0] l, input logic [7:0] rd0, input int ph,
                           input bit wait_end);
        int    ln   = (l == 4'd0) ? 1 : int'(l);
        bit    fifo = (op_i == 2'b10);
        bit    wr   = (op_i == 2'b00);
        int    hdr  = fifo ? 1 : 2;
        int    n    = 0;
        done_t d;
        wait_idle("idle_before_start");
        for (int i = 0; i < 18; i++)
            miso_tab[i] = (i < hdr) ? 8'hFF : rd0 + 8'(i - hdr);
        exp_mosi_q.push_back(wr ? 8'h0A : (fifo ? 8'h0D : 8'h0B));
        if (!fifo) exp_mosi_q.push_back(a);
        for (int i = 0; i < ln; i++) begin
            exp_mosi_q.push_back(wr ? w : 8'h00);
            if (!wr) exp_rd_q.push_back(rd0 + 8'(i));
        end
        d.low = 8 * (hdr + ln);
        d.rv  = !wr;
        exp_done_q.push_back(d);
        while (int'(cnt) != ph && n < 16) begin
            @(negedge sclk_o);
            n++;
        end
        pulse_start(op_i, a, w, l);
        if (wait_end) wait_idle("txn_complete");
    endtask

    initial begin
        int n;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.addr  = 8'h00;
        bus.wdata = 8'h00;
        bus.len   = 4'd0;
        for (int i = 0; i < 18; i++) miso_tab[i] = 8'hFF;

        // Reset values
        #12;
        chk("rst_ncs", int'(ncs_o), 1);
        chk("rst_tx", int'(spi_tx_data), 0);
        chk("rst_rdata", int'(bus.rdata), 0);
        chk("rst_rv", int'(bus.rdata_valid), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        @(negedge sclk_o);
        rst = 1'b0;
        repeat (3) @(negedge sclk_o);

        // Reset asserted in the middle of the address byte of a write
        pulse_start(2'b00, 8'h2D, 8'h02, 4'd1);
        n = 0;
        while (ncs_o && n < 20) begin
            @(negedge sclk_o);
            n++;
        end
        chk("abort_ncs_fell", int'(ncs_o), 0);
        repeat (10) @(negedge sclk_o);
        chk("abort_busy_before", int'(bus.busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_ncs", int'(ncs_o), 1);
        chk("abort_tx", int'(spi_tx_data), 0);
        chk("abort_rdata", int'(bus.rdata), 0);
        chk("abort_rv", int'(bus.rdata_valid), 0);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        repeat (3) @(negedge sclk_o);
        rst = 1'b0;
        mon_en = 1'b1;

        // Write 0x2D <- 0x02
        run_txn(2'b00, 8'h2D, 8'h02, 4'd1, 8'h00, 3, 1);
        // Read 0x00, slave returns 0xAD
        run_txn(2'b01, 8'h00, 8'h00, 4'd1, 8'hAD, 5, 1);
        // Burst read 0x0E, 6 bytes 0x10..0x15
        run_txn(2'b01, 8'h0E, 8'h00, 4'd6, 8'h10, 0, 1);
        // FIFO read, len 0 treated as 1
        run_txn(2'b10, 8'h55, 8'h00, 4'd0, 8'h7C, 7, 1);
        // Multi-byte write repeats wdata; op 11 behaves as read
        run_txn(2'b00, 8'h1F, 8'hA5, 4'd3, 8'h00, 2, 1);
        run_txn(2'b11, 8'h08, 8'h00, 4'd2, 8'hE0, 4, 1);

        // start while busy: once while pending, once mid-frame
        run_txn(2'b01, 8'h0E, 8'h00, 4'd4, 8'h30, 1, 0);
        pulse_start(2'b00, 8'h99, 8'h66, 4'd2);
        repeat (12) @(negedge sclk_o);
        pulse_start(2'b10, 8'h00, 8'h00, 4'd5);
        wait_idle("busy_txn_complete");

        // Request at every engine phase
        for (int ph = 0; ph < 8; ph++)
            run_txn(2'b00, 8'h20 + 8'(ph), 8'h40 + 8'(ph), 4'd1, 8'h00, ph, 1);

        // Nothing extra may appear once idle
        repeat (40) @(negedge sclk_o);
        chk("end_busy", int'(bus.busy), 0);
        chk("end_ncs", int'(ncs_o), 1);
        chk("mosi_q_empty", exp_mosi_q.size(), 0);
        chk("rd_q_empty", exp_rd_q.size(), 0);
        chk("done_q_empty", exp_done_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
